divider_block: RTL and testbench
================================

DIVIDER_BLOCK -- requirements
Module: divider_block

Interface
REQ-001 Parameter data_size, default 32: width of exp values, sum and quotient.
REQ-002 Parameter number_of_data, default 10: elements per softmax vector.
REQ-003 Parameter frac_bits, default 16: fractional bits in exp values, sum and quotient (unsigned fixed point).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clock_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n_i  input  1  asynchronous active-low reset.
REQ-007 sum_i  input  data_size  accumulated exp sum (divisor), produced by the adder stage.
REQ-008 sum_valid_i  input  1  level-high once sum_i is final; may remain high indefinitely.
REQ-009 exp_data_i  input  data_size  exp value (dividend) replayed from the exp buffer.
REQ-010 exp_data_valid_i  input  1  exp_data_i valid.
REQ-011 exp_data_ready_o  output  1  block accepts exp_data_i this cycle.
REQ-012 div_o  output  data_size  quotient exp/sum, frac_bits fractional bits.
REQ-013 div_valid_o  output  1  div_o valid; held until accepted.
REQ-014 div_ready_i  input  1  downstream accepts div_o.
REQ-015 div_done_o  output  1  one-cycle pulse after the last quotient of a vector is accepted.
REQ-016 busy_o  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, WAIT_DATA, DIVIDE, OUTPUT, DONE.
REQ-018 IDLE: on a 0->1 transition of sum_valid_i (registered edge detect), latch sum_i into the divisor register, clear the element counter, go to WAIT_DATA; a level held high from before the edge SHALL NOT re-trigger.
REQ-019 WAIT_DATA: exp_data_ready_o=1; a transfer occurs when exp_data_valid_i && exp_data_ready_o; on transfer, load the dividend (exp_data_i << frac_bits, data_size+frac_bits bits) and go to DIVIDE.
REQ-020 exp_data_ready_o SHALL be 0 in every state except WAIT_DATA.
REQ-021 DIVIDE: restoring division, one quotient bit per cycle, exactly data_size+frac_bits cycles (48 at defaults), then OUTPUT.
REQ-022 OUTPUT: div_valid_o=1 with div_o stable; on div_valid_o && div_ready_i increment the element counter; go to DONE if the counter reaches number_of_data, else WAIT_DATA.
REQ-023 Latency: div_valid_o rises data_size+frac_bits+1 cycles after the accepting exp handshake edge.
REQ-024 Quotient wider than data_size bits SHALL saturate div_o to all ones.
REQ-025 Latched divisor of zero: div_o SHALL be all ones; DIVIDE timing unchanged.
REQ-026 DONE: div_done_o=1 for exactly one cycle, then IDLE.
REQ-027 sum_i and sum_valid_i changes outside IDLE SHALL be ignored; the latched divisor is used for the whole vector.
REQ-028 Downstream stall (div_ready_i=0) SHALL hold OUTPUT indefinitely with div_o unchanged.
REQ-029 Element counter width: clog2(number_of_data+1); no wrap within a vector.

Reset
REQ-030 On reset_n_i low, asynchronously: state IDLE; div_o=0, div_valid_o=0, div_done_o=0, exp_data_ready_o=0, busy_o=0; divisor, dividend, counters and edge-detect register cleared.
REQ-031 Reset mid-vector SHALL abandon the vector; after release, a new sum_valid_i 0->1 edge is required to restart.

Verification
REQ-032 sum_i=0x0002_0000 (2.0), exp_data_i=0x0000_8000 (0.5), div_ready_i=1 -> div_o=0x0000_4000 (0.25), div_valid_o 49 cycles after exp handshake.
REQ-033 Full vector of 10 elements, each exp=0x0000_1999, sum=0x0001_0000 -> ten quotients 0x0000_1999, one div_done_o pulse, return to IDLE, busy_o=0.
REQ-034 sum_i=0 -> every div_o=0xFFFF_FFFF; exp=0x0004_0000, sum=0x0000_0001 -> saturates to 0xFFFF_FFFF.
REQ-035 div_ready_i held 0 for 20 cycles in OUTPUT -> div_o/div_valid_o stable, exp_data_ready_o=0, no counter advance.
REQ-036 sum_valid_i held high after DONE -> no restart; drop then raise -> new vector starts with newly latched sum_i.
REQ-037 reset_n_i asserted mid-DIVIDE of element 5 -> all outputs 0 immediately; no div_done_o until a new sum edge and full vector.

Source files
------------

// File: rtl/divider_block.sv
// Softmax normaliser stage: divides each replayed exp value by the latched exp sum.
// Restoring divider, one quotient bit per cycle, unsigned fixed point with frac_bits fraction bits.
module divider_block #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10,
    parameter int frac_bits      = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [data_size-1:0] sum_i,
    input  logic                 sum_valid_i,
    input  logic [data_size-1:0] exp_data_i,
    input  logic                 exp_data_valid_i,
    output logic                 exp_data_ready_o,
    output logic [data_size-1:0] div_o,
    output logic                 div_valid_o,
    input  logic                 div_ready_i,
    output logic                 div_done_o,
    output logic                 busy_o
);

    localparam int QW = data_size + frac_bits;
    localparam int BW = $clog2(QW + 1);
    localparam int CW = $clog2(number_of_data + 1);
    localparam logic [CW-1:0] LAST_ELEM = CW'(number_of_data - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_DATA = 3'd1;
    localparam logic [2:0] DIVIDE    = 3'd2;
    localparam logic [2:0] OUTPUT    = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    logic [2:0]           r_state;
    logic                 r_sum_valid_d;
    logic [data_size-1:0] r_divisor;
    logic [data_size-1:0] r_rem;
    logic [QW-1:0]        r_quo;
    logic [BW-1:0]        r_bit_cnt;
    logic [CW-1:0]        r_elem_cnt;
    logic [data_size-1:0] r_div;

    logic                 w_sum_rise;
    logic [data_size:0]   w_rem_shift;
    logic                 w_fits;
    logic [data_size-1:0] w_trial;
    logic                 w_overflow;

    assign w_sum_rise  = sum_valid_i & ~r_sum_valid_d;

    // r_quo starts as the shifted dividend; its MSB feeds the remainder while quotient bits fill from the LSB.
    assign w_rem_shift = {r_rem, r_quo[QW-1]};
    assign w_fits      = (w_rem_shift >= {1'b0, r_divisor});
    assign w_trial     = w_rem_shift[data_size-1:0] - r_divisor;
    assign w_overflow  = |r_quo[QW-1:data_size];

    assign exp_data_ready_o = (r_state == WAIT_DATA);
    assign div_valid_o      = (r_state == OUTPUT);
    assign div_done_o       = (r_state == DONE);
    assign busy_o           = (r_state != IDLE);
    assign div_o            = r_div;

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= IDLE;
            r_sum_valid_d <= 1'b0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_bit_cnt     <= '0;
            r_elem_cnt    <= '0;
            r_div         <= '0;
        end else begin
            r_sum_valid_d <= sum_valid_i;
            case (r_state)
                IDLE: begin
                    if (w_sum_rise) begin
                        r_divisor  <= sum_i;
                        r_elem_cnt <= '0;
                        r_state    <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (exp_data_valid_i) begin
                        r_quo     <= {exp_data_i, {frac_bits{1'b0}}};
                        r_rem     <= '0;
                        r_bit_cnt <= BW'(QW);
                        r_state   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (r_bit_cnt != '0) begin
                        r_rem     <= w_fits ? w_trial : w_rem_shift[data_size-1:0];
                        r_quo     <= {r_quo[QW-2:0], w_fits};
                        r_bit_cnt <= r_bit_cnt - BW'(1);
                    end else begin
                        // Zero divisor and quotients too wide for div_o both clamp to full scale.
                        r_div   <= (r_divisor == '0 || w_overflow) ? '1 : r_quo[data_size-1:0];
                        r_state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (div_ready_i) begin
                        r_elem_cnt <= r_elem_cnt + CW'(1);
                        r_state    <= (r_elem_cnt == LAST_ELEM) ? DONE : WAIT_DATA;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_block.sv
// Scoreboard bench for divider_block: stimulus pushes hand-computed quotients,
// an independent monitor pops and compares on every accepted div_o.
module tb_divider_block;

    localparam int N = 10;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] sum_i;
    logic        sum_valid_i;
    logic [31:0] exp_data_i;
    logic        exp_data_valid_i;
    logic        exp_data_ready_o;
    logic [31:0] div_o;
    logic        div_valid_o;
    logic        div_ready_i;
    logic        div_done_o;
    logic        busy_o;

    always #5 clock_i = ~clock_i;

    divider_block #(.data_size(32), .number_of_data(N), .frac_bits(16)) dut (
        .clock_i          (clock_i),
        .reset_n_i        (reset_n_i),
        .sum_i            (sum_i),
        .sum_valid_i      (sum_valid_i),
        .exp_data_i       (exp_data_i),
        .exp_data_valid_i (exp_data_valid_i),
        .exp_data_ready_o (exp_data_ready_o),
        .div_o            (div_o),
        .div_valid_o      (div_valid_o),
        .div_ready_i      (div_ready_i),
        .div_done_o       (div_done_o),
        .busy_o           (busy_o)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          done_before;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] tab_e[N];
    logic [31:0] tab_q[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: a quotient is consumed on every negedge where valid and ready are both high.
    initial begin
        forever begin
            @(negedge clock_i);
            if (div_done_o) n_done++;
            if (reset_n_i && div_valid_o && div_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL div_o unexpected: got %0h, expected none", div_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("div_o", {32'h0, div_o}, {32'h0, mon_exp});
                end
            end
        end
    end

    task automatic start_vector(input logic [31:0] s);
        @(posedge clock_i); #1 sum_valid_i = 1'b0;
        @(posedge clock_i); #1 sum_i = s; sum_valid_i = 1'b1;
        @(posedge clock_i); #1 check("busy_after_start", busy_o, 1);
    endtask

    task automatic send_exp(input logic [31:0] e, input logic [31:0] q, input bit track);
        int k;
        if (track) exp_q.push_back(q);
        exp_data_i       = e;
        exp_data_valid_i = 1'b1;
        k = 0;
        do begin
            @(negedge clock_i);
            k++;
        end while (!exp_data_ready_o && k < 500);
        if (!exp_data_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL exp_handshake: got timeout, expected ready");
        end
        @(posedge clock_i); #1 exp_data_valid_i = 1'b0;
        if (track) begin
            k = 0;
            while (!div_valid_o && k < 200) begin
                @(posedge clock_i); #1;
                k++;
            end
            check("latency", k, 49);
        end
    endtask

    task automatic send_table(input int from);
        for (int i = from; i < N; i++) send_exp(tab_e[i], tab_q[i], 1'b1);
    endtask

    task automatic finish_vector();
        int k;
        k = 0;
        while (!div_done_o && k < 20) begin
            @(negedge clock_i);
            k++;
        end
        check("done_pulse", div_done_o, 1);
        @(negedge clock_i);
        check("done_one_cycle", div_done_o, 0);
        check("idle_busy", busy_o, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, exp_data_ready_o, 0);
        check({tag, "_valid"}, div_valid_o, 0);
        check({tag, "_div_o"}, div_o, 0);
        check({tag, "_done"},  div_done_o, 0);
        check({tag, "_busy"},  busy_o, 0);
    endtask

    initial begin
        reset_n_i = 1'b0;
        sum_i = '0; sum_valid_i = 1'b0;
        exp_data_i = '0; exp_data_valid_i = 1'b0;
        div_ready_i = 1'b1;
        repeat (3) @(posedge clock_i);
        #1 check_outputs_zero("reset");
        reset_n_i = 1'b1;

        // Divisor 2.0: quotient is exp/2 in raw units.
        tab_e = '{32'h0000_8000, 32'h0001_0000, 32'h0003_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                  32'h0000_0001, 32'h0000_0003, 32'h0001_2345, 32'h0000_0100, 32'h0000_0007};
        tab_q = '{32'h0000_4000, 32'h0000_8000, 32'h0001_8000, 32'h0000_0000, 32'h7FFF_FFFF,
                  32'h0000_0000, 32'h0000_0001, 32'h0000_91A2, 32'h0000_0080, 32'h0000_0003};
        start_vector(32'h0002_0000);
        send_table(0);
        finish_vector();

        // sum_valid_i still high from the previous vector: must not restart.
        repeat (10) @(posedge clock_i);
        #1 check("no_retrigger_busy", busy_o, 0);
        check("no_retrigger_ready", exp_data_ready_o, 0);

        // Divisor 1.0: quotients equal the dividends.
        for (int i = 0; i < N; i++) begin
            tab_e[i] = 32'h0000_1999;
            tab_q[i] = 32'h0000_1999;
        end
        start_vector(32'h0001_0000);
        send_table(0);
        finish_vector();

        // Zero divisor: every quotient is full scale.
        tab_e = '{32'h0000_8000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0001_0000,
                  32'h0000_1999, 32'h0004_0000, 32'h0000_00FF, 32'h1234_5678, 32'h0000_0002};
        for (int i = 0; i < N; i++) tab_q[i] = 32'hFFFF_FFFF;
        start_vector(32'h0000_0000);
        send_table(0);
        finish_vector();

        // Smallest divisor: quotient is exp << 16, saturating above 32 bits.
        tab_e = '{32'h0004_0000, 32'h0000_FFFF, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000,
                  32'h0000_8000, 32'h0000_FFFE, 32'hFFFF_FFFF, 32'h0000_0012, 32'h0000_1234};
        tab_q = '{32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0000,
                  32'h8000_0000, 32'hFFFE_0000, 32'hFFFF_FFFF, 32'h0012_0000, 32'h1234_0000};
        start_vector(32'h0000_0001);
        send_table(0);
        finish_vector();

        // Divisor 4.0 with a 20-cycle downstream stall and a mid-vector sum change.
        tab_e = '{32'h0001_0000, 32'h0004_0000, 32'h0000_0004, 32'h0000_0003, 32'hFFFF_FFFF,
                  32'h0000_2000, 32'h0010_0000, 32'h0000_0005, 32'h0000_0008, 32'h0000_1000};
        tab_q = '{32'h0000_4000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 32'h3FFF_FFFF,
                  32'h0000_0800, 32'h0004_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0400};
        start_vector(32'h0004_0000);
        div_ready_i = 1'b0;
        send_exp(tab_e[0], tab_q[0], 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_i);
            check("stall_valid", div_valid_o, 1);
            check("stall_div_o", div_o, 32'h0000_4000);
            check("stall_ready", exp_data_ready_o, 0);
            if (i == 5) begin
                sum_i = 32'h0000_0001;
                sum_valid_i = 1'b0;
            end
            if (i == 8) sum_valid_i = 1'b1;
        end
        @(posedge clock_i); #1 div_ready_i = 1'b1;
        send_table(1);
        finish_vector();

        // Reset during the divide of element 5 abandons the vector.
        for (int i = 0; i < N; i++) begin
            tab_e[i] = 32'h0000_1999;
            tab_q[i] = 32'h0000_1999;
        end
        start_vector(32'h0001_0000);
        for (int i = 0; i < 4; i++) send_exp(tab_e[i], tab_q[i], 1'b1);
        send_exp(tab_e[4], 32'h0, 1'b0);
        repeat (20) @(posedge clock_i);
        #3 reset_n_i = 1'b0;
        sum_valid_i = 1'b0;
        #1 check_outputs_zero("mid_reset");
        exp_q.delete();
        repeat (3) @(posedge clock_i);
        #1 reset_n_i = 1'b1;
        done_before = n_done;
        repeat (80) @(posedge clock_i);
        #1 check("post_reset_busy", busy_o, 0);
        check("post_reset_no_done", n_done, done_before);

        start_vector(32'h0001_0000);
        send_table(0);
        finish_vector();

        repeat (5) @(posedge clock_i);
        check("total_done_pulses", n_done, 6);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
